// File: rtl/ws2812_pio_ctrl.sv
// ws2812_pio_ctrl: owns the PIO host interface for one WS2812 strip.
// The first start after reset loads the program and the machine configuration.
// Every start streams NPIX GRB pixels into the TX FIFO, waits for the FIFO to
// drain, then holds the latch gap before pulsing done.
//
// Handshake: start is accepted only in IDLE (busy=0). Every non-NONE action is
// a single-cycle command to the PIO and is always followed by a NONE cycle.
// A PUSH is only issued after full[MINDEX] has been seen low in the previous
// cycle, so the FIFO is never overrun.
module ws2812_pio_ctrl #(
  parameter int          PLEN         = 4,
  parameter logic [23:0] DIV          = 24'h0535,
  parameter logic [31:0] PIN_GRPS     = 32'h20000000,
  parameter logic [5:0]  SIDES_CFG    = 6'b100001,
  parameter logic [31:0] SHIFT_CFG    = 32'h30020000,
  parameter int          MINDEX       = 0,
  parameter int          NPIX         = 8,
  parameter int          LATCH_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [7:0]  pix_addr,
  input  logic [23:0] pix_data,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  input  logic [3:0]  full,
  input  logic [3:0]  empty,
  output logic [2:0]  dbg_state_o
);

  localparam int LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [3:0] A_NONE  = 4'd0;
  localparam logic [3:0] A_INSTR = 4'd1;
  localparam logic [3:0] A_PEND  = 4'd2;
  localparam logic [3:0] A_PUSH  = 4'd4;
  localparam logic [3:0] A_GRPS  = 4'd5;
  localparam logic [3:0] A_EN    = 4'd6;
  localparam logic [3:0] A_DIV   = 4'd7;
  localparam logic [3:0] A_SIDES = 4'd8;
  localparam logic [3:0] A_SHIFT = 4'd10;

  localparam logic [4:0]    LAST_INSTR = 5'(PLEN - 1);
  localparam logic [7:0]    LAST_PIX   = 8'(NPIX - 1);
  localparam logic [LW-1:0] LAST_LATCH = LW'(LATCH_CYCLES - 1);
  localparam logic [2:0]    LAST_CFG   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CONFIG = 3'd2,
    S_FETCH  = 3'd3,
    S_PUSH   = 3'd4,
    S_DRAIN  = 3'd5,
    S_LATCH  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic          configured_q, configured_d;
  logic [1:0]    ph_q, ph_d;
  logic [2:0]    step_q, step_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [3:0]    action_q, action_d;
  logic [31:0]   din_q, din_d;
  logic [4:0]    index_q, index_d;
  logic [4:0]    prog_addr_q, prog_addr_d;
  logic [7:0]    pix_addr_q, pix_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0]  cfg_act;
  logic [31:0] cfg_din;
  logic        full_m;
  logic        empty_m;
  logic        unused_ok;

  assign full_m  = full[MINDEX];
  assign empty_m = empty[MINDEX];
  // Only the selected machine's FIFO flags matter; the rest are deliberately ignored.
  assign unused_ok = ^{full, empty};

  assign busy        = busy_q;
  assign done        = done_q;
  assign prog_addr   = prog_addr_q;
  assign pix_addr    = pix_addr_q;
  assign action      = action_q;
  assign index       = index_q;
  assign din         = din_q;
  assign mindex      = 2'(MINDEX);
  assign dbg_state_o = state_q;

  // Configuration command table, walked in fixed order by step_q.
  always_comb begin
    cfg_act = A_NONE;
    cfg_din = 32'h0;
    case (step_q)
      3'd0: begin cfg_act = A_PEND;  cfg_din = 32'(PLEN - 1);      end
      3'd1: begin cfg_act = A_DIV;   cfg_din = {8'h0, DIV};        end
      3'd2: begin cfg_act = A_GRPS;  cfg_din = PIN_GRPS;           end
      3'd3: begin cfg_act = A_SIDES; cfg_din = {26'h0, SIDES_CFG}; end
      3'd4: begin cfg_act = A_SHIFT; cfg_din = SHIFT_CFG;          end
      3'd5: begin cfg_act = A_EN;    cfg_din = 32'h1;              end
      default: begin cfg_act = A_NONE; cfg_din = 32'h0; end
    endcase
  end

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    configured_d = configured_q;
    ph_d         = ph_q;
    step_d       = step_q;
    lcnt_d       = lcnt_q;
    action_d     = A_NONE;
    din_d        = din_q;
    index_d      = index_q;
    prog_addr_d  = prog_addr_q;
    pix_addr_d   = pix_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          prog_addr_d = 5'd0;
          pix_addr_d  = 8'd0;
          ph_d        = 2'd0;
          step_d      = 3'd0;
          state_d     = configured_q ? S_FETCH : S_LOAD;
        end
      end

      // ph 0: address out, ph 1: ROM word valid -> issue INSTR, ph 2: INSTR on bus.
      S_LOAD: begin
        case (ph_q)
          2'd0: ph_d = 2'd1;
          2'd1: begin
            action_d = A_INSTR;
            index_d  = prog_addr_q;
            din_d    = {16'h0, prog_data};
            ph_d     = 2'd2;
          end
          default: begin
            ph_d = 2'd0;
            if (prog_addr_q == LAST_INSTR) begin
              step_d  = 3'd0;
              state_d = S_CONFIG;
            end else begin
              prog_addr_d = prog_addr_q + 5'd1;
            end
          end
        endcase
      end

      // ph 0 issues the command, ph 1 is the command cycle on the bus.
      S_CONFIG: begin
        if (ph_q == 2'd0) begin
          action_d = cfg_act;
          din_d    = cfg_din;
          ph_d     = 2'd1;
        end else begin
          ph_d = 2'd0;
          if (step_q == LAST_CFG) begin
            configured_d = 1'b1;
            pix_addr_d   = 8'd0;
            state_d      = S_FETCH;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end

      // Pixel address is on the bus; RAM data is valid in the next cycle.
      S_FETCH: begin
        ph_d    = 2'd0;
        state_d = S_PUSH;
      end

      // ph 0 waits for FIFO room, ph 1 is the PUSH cycle; the NONE that follows is FETCH or DRAIN.
      S_PUSH: begin
        if (ph_q == 2'd0) begin
          if (!full_m) begin
            action_d = A_PUSH;
            din_d    = {pix_data, 8'h00};
            ph_d     = 2'd1;
          end
        end else begin
          ph_d = 2'd0;
          if (pix_addr_q == LAST_PIX) begin
            state_d = S_DRAIN;
          end else begin
            pix_addr_d = pix_addr_q + 8'd1;
            state_d    = S_FETCH;
          end
        end
      end

      S_DRAIN: begin
        if (empty_m) begin
          lcnt_d  = '0;
          state_d = S_LATCH;
        end
      end

      S_LATCH: begin
        if (lcnt_q == LAST_LATCH) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame and forces a reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      configured_q <= 1'b0;
      ph_q         <= 2'd0;
      step_q       <= 3'd0;
      lcnt_q       <= '0;
      action_q     <= A_NONE;
      din_q        <= 32'h0;
      index_q      <= 5'd0;
      prog_addr_q  <= 5'd0;
      pix_addr_q   <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      configured_q <= configured_d;
      ph_q         <= ph_d;
      step_q       <= step_d;
      lcnt_q       <= lcnt_d;
      action_q     <= action_d;
      din_q        <= din_d;
      index_q      <= index_d;
      prog_addr_q  <= prog_addr_d;
      pix_addr_q   <= pix_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule
